config_loader: RTL and testbench

Serial configuration loader for the CGRA fabric. It accepts a configuration bitstream as parallel words over a valid/ready handshake and shifts it, LSB first, into the daisy-chained config_cell chain through the chain's config_clk/config_reset/config_in/config_out ports. One loader drives one chain, for example a row of BlockIO and PE cells. The loader sits between the host/DMA bitstream source and the fabric's configuration ports.

---
 rtl/config_loader_pkg.sv | 24 ++
 rtl/config_loader_if.sv | 11 +
 rtl/config_loader_crc16.sv | 34 +++
 rtl/config_loader.sv | 163 ++++++++++++++++
 tb/tb_config_loader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/config_loader_pkg.sv
// Shared types and constants for the config_loader block.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    FETCH,
    SLO,
    SHI,
    FIN
  } state_e;

  localparam int          CRST_CYCLES = 2;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;

  // One MSB-first, non-reflected CRC-16 step for a single input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// Bitstream word handshake between the host/DMA source and the loader.
interface config_loader_if #(
  parameter int WORD = 32
);
  logic            word_valid;
  logic            word_ready;
  logic [WORD-1:0] word_data;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/config_loader_crc16.sv
// Bit-serial CRC-16 engine: one bit folded in per enabled cycle.
module config_loader_crc16
  import config_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: shifts bitstream words LSB first into a config_cell chain.
// Optional readback CRC of the displaced chain contents under CONFIG_LOADER_CRC_EN.
//
// state | meaning
// IDLE  | waiting for start
// CRST  | chain reset held for CRST_CYCLES
// FETCH | word_ready high, waiting for a bitstream word
// SLO   | config_clk low, config_in set up
// SHI   | config_clk high, chain shifts
// FIN   | load complete, done follows next cycle
module config_loader
  import config_loader_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] chain_len_i,
  config_loader_if.slave   word_if,
  output logic             config_clk_o,
  output logic             config_reset_o,
  output logic             config_in_o,
  input  logic             config_out_i,
  output logic             busy_o,
`ifdef CONFIG_LOADER_CRC_EN
  output logic [15:0]      readback_crc_o,
`endif
  output logic             done_o
);

  localparam int IDX_W = (WORD > 1) ? $clog2(WORD) : 1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_bits_q, rem_bits_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WORD-1:0]  shreg_q, shreg_d;
  logic [1:0]       crst_cnt_q, crst_cnt_d;
  logic             cfg_in_q, cfg_in_d;
  logic             cfg_clk_q, cfg_clk_d;
  logic             cfg_rst_q, cfg_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d    = state_q;
    rem_bits_d = rem_bits_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    crst_cnt_d = crst_cnt_q;
    cfg_in_d   = cfg_in_q;

    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_bits_d = chain_len_i;
            crst_cnt_d = '0;
            state_d    = (chain_len_i == '0) ? FIN : CRST;
          end
        end
        CRST: begin
          if (crst_cnt_q == 2'(CRST_CYCLES - 1)) begin
            state_d = FETCH;
          end else begin
            crst_cnt_d = crst_cnt_q + 2'd1;
          end
        end
        FETCH: begin
          if (word_if.word_valid) begin
            shreg_d   = word_if.word_data;
            bit_idx_d = '0;
            cfg_in_d  = word_if.word_data[0];
            state_d   = SLO;
          end
        end
        SLO: begin
          state_d = SHI;
        end
        SHI: begin
          rem_bits_d = rem_bits_q - LEN_W'(1);
          shreg_d    = shreg_q >> 1;
          bit_idx_d  = bit_idx_q + IDX_W'(1);
          if (rem_bits_q == LEN_W'(1)) begin
            state_d = FIN;
          end else if (bit_idx_q == IDX_W'(WORD - 1)) begin
            state_d = FETCH;
          end else begin
            // next bit is presented while config_clk is low
            cfg_in_d = shreg_q[1];
            state_d  = SLO;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    cfg_clk_d = (state_d == SHI);
    cfg_rst_d = (state_d == CRST);
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == FIN) && !abort_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      rem_bits_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      crst_cnt_q <= '0;
      cfg_in_q   <= 1'b0;
      cfg_clk_q  <= 1'b0;
      cfg_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_bits_q <= rem_bits_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      crst_cnt_q <= crst_cnt_d;
      cfg_in_q   <= cfg_in_d;
      cfg_clk_q  <= cfg_clk_d;
      cfg_rst_q  <= cfg_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign word_if.word_ready = (state_q == FETCH) && !abort_i;
  assign config_clk_o       = cfg_clk_q;
  assign config_reset_o     = cfg_rst_q;
  assign config_in_o        = cfg_in_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

`ifdef CONFIG_LOADER_CRC_EN
  logic crc_init;
  assign crc_init = (state_q == IDLE) && start_i && !abort_i;

  config_loader_crc16 u_crc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .init_i  (crc_init),
    .en_i    (state_q == SLO),
    .bit_i   (config_out_i),
    .crc_o   (readback_crc_o)
  );
`else
  logic unused_config_out;
  assign unused_config_out = config_out_i;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader; also covers the readback CRC when CONFIG_LOADER_CRC_EN is defined.
module tb_config_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] chain_len = '0;
  logic        cfg_clk, cfg_rst, cfg_in, cfg_out, busy, done;
`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] crc;
`endif

  always #5 clk = ~clk;

  config_loader_if #(.WORD(32)) wif ();

  config_loader #(.WORD(32), .LEN_W(16)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .start_i        (start),
    .abort_i        (abort),
    .chain_len_i    (chain_len),
    .word_if        (wif.slave),
    .config_clk_o   (cfg_clk),
    .config_reset_o (cfg_rst),
    .config_in_o    (cfg_in),
    .config_out_i   (cfg_out),
    .busy_o         (busy),
`ifdef CONFIG_LOADER_CRC_EN
    .readback_crc_o (crc),
`endif
    .done_o         (done)
  );

  // behavioural 32-cell chain: first cell at [0], last cell drives config_out
  logic [31:0] chain = '0;
  always @(posedge cfg_clk) chain <= {chain[30:0], cfg_in};
  assign cfg_out = chain[31];

  typedef struct {
    int              len;
    logic [2:0][31:0] w;
    int              stall;
    int              abort_at;
    int              exp_words;
    int              exp_edges;
    int              exp_done;
  } vec_t;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic exp_q[$];

  task automatic check(input string name, input longint act, input longint req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  function automatic vec_t mk(input int len, input logic [31:0] w0, input logic [31:0] w1,
                              input int stall, input int abort_at, input int ew,
                              input int ee, input int ed);
    vec_t v;
    v.len = len; v.w = {32'h5EED_0BAD, w1, w0}; v.stall = stall; v.abort_at = abort_at;
    v.exp_words = ew; v.exp_edges = ee; v.exp_done = ed;
    return v;
  endfunction

  function automatic logic [15:0] crc_ref(input logic [31:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic run_load(input vec_t v, input string tag);
    int n, edges, words, rstc, rst_bad, donec, donecyc, readyc, stall_left, stall_bad;
    int bit_bad, ab_cyc, ptr;
    logic aborted, prev, busy1, b;
    edges = 0; words = 0; rstc = 0; rst_bad = 0; donec = 0; donecyc = 0; readyc = 0;
    stall_left = v.stall; stall_bad = 0; bit_bad = 0; ab_cyc = 0; ptr = 0;
    aborted = 0; prev = 0; busy1 = 0;
    n = (v.abort_at > 0) ? v.abort_at : v.len;
    for (int i = 0; i < n; i++) exp_q.push_back(v.w[i / 32][i % 32]);

    @(negedge clk);
    start = 1'b1; chain_len = v.len[15:0]; wif.word_valid = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (cfg_clk && !prev) begin
        edges++;
        if (exp_q.size() == 0) bit_bad++;
        else begin
          b = exp_q.pop_front();
          if (b !== cfg_in) bit_bad++;
        end
      end
      prev = cfg_clk;
      if (cfg_rst) begin rstc++; if (cyc > 2) rst_bad++; end
      if (done) begin donec++; donecyc = cyc; end
      if (cyc == 1) busy1 = busy;
      if (aborted && cyc == ab_cyc + 1) begin
        check({tag, " busy after abort"}, busy, 0);
        check({tag, " config_clk after abort"}, cfg_clk, 0);
      end
      if (v.abort_at > 0 && !aborted && edges == v.abort_at) begin
        abort = 1'b1; aborted = 1'b1; ab_cyc = cyc;
      end
      #1;
      if (ptr == 1 && wif.word_ready && stall_left > 0) begin
        wif.word_valid = 1'b0;
        stall_left--;
        if (cfg_clk) stall_bad++;
      end else begin
        wif.word_valid = (ptr < 3);
        wif.word_data  = (ptr < 3) ? v.w[ptr] : 32'h0;
      end
      if (wif.word_ready) readyc++;
      if (wif.word_valid && wif.word_ready) begin words++; ptr++; end
      if (donec > 0 && cyc >= donecyc + 2) break;
      if (aborted && cyc >= ab_cyc + 10) break;
    end
    wif.word_valid = 1'b0;

    check({tag, " words consumed"}, words, v.exp_words);
    check({tag, " config_clk rises"}, edges, v.exp_edges);
    check({tag, " config_in bit errors"}, bit_bad, 0);
    check({tag, " bits left unshifted"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, " busy at cycle 1"}, busy1, 1);
    check({tag, " config_reset cycles"}, rstc, (v.len != 0) ? 2 : 0);
    check({tag, " config_reset outside cycles 1-2"}, rst_bad, 0);
    if (v.exp_done > 0) begin
      check({tag, " done pulses"}, donec, 1);
      check({tag, " done cycle"}, donecyc, v.exp_done);
    end else begin
      check({tag, " done pulses"}, donec, 0);
    end
    if (v.stall > 0) check({tag, " config_clk high during stall"}, stall_bad, 0);
    if (v.len == 0) check({tag, " word_ready cycles"}, readyc, 0);
  endtask

  vec_t tbl[7];
  vec_t v1;
  logic shi_seen;

  initial begin
    wif.word_valid = 1'b0;
    wif.word_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset outputs", {busy, cfg_clk, cfg_rst, cfg_in, done, wif.word_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = mk(40, 32'hA5A5_A5A5, 32'h0000_00FF, 0, 0, 2, 40, 86);
    tbl[1] = mk(0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 2);
    tbl[2] = mk(1,  32'h0000_0001, 32'h0000_0000, 0, 0, 1, 1, 7);
    tbl[3] = mk(32, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0, 1, 32, 69);
    tbl[4] = mk(40, 32'hA5A5_A5A5, 32'h0000_00FF, 5, 0, 2, 40, 91);
    tbl[5] = mk(64, 32'h0F0F_1234, 32'hCAFE_F00D, 0, 17, 1, 17, 0);
    tbl[6] = mk(33, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 2, 33, 72);
    for (int i = 0; i < 7; i++) begin
      run_load(tbl[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // abort while a word is offered in FETCH: the word must not be taken
    start = 1'b1; chain_len = 16'd40;
    wif.word_valid = 1'b1; wif.word_data = 32'h1357_9BDF;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("fetch ready before abort", wif.word_ready, 1);
    abort = 1'b1;
    #1;
    check("fetch ready during abort", wif.word_ready, 0);
    @(negedge clk);
    abort = 1'b0; wif.word_valid = 1'b0;
    check("fetch abort busy", busy, 0);
    repeat (3) @(negedge clk);

    // reset asserted while config_clk is high
    start = 1'b1; chain_len = 16'd40;
    wif.word_valid = 1'b1; wif.word_data = 32'hA5A5_A5A5;
    shi_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cfg_clk) begin shi_seen = 1'b1; break; end
    end
    check("reached SHI before reset", shi_seen, 1);
    rst = 1'b1;
    #1;
    check("async reset outputs", {busy, cfg_clk, cfg_rst, cfg_in, done, wif.word_ready}, 0);
    @(negedge clk);
    rst = 1'b0; wif.word_valid = 1'b0;
    @(negedge clk);
    run_load(tbl[2], "after reset");

`ifdef CONFIG_LOADER_CRC_EN
    repeat (2) @(negedge clk);
    run_load(mk(32, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 32, 69), "crc fill");
    repeat (2) @(negedge clk);
    v1 = mk(32, 32'h0000_0000, 32'h0, 0, 0, 1, 32, 69);
    run_load(v1, "crc readback");
    check("readback_crc", crc, crc_ref(32'hDEAD_BEEF));
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1);
  end

endmodule
